// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch stage: one outstanding I-memory read feeding a DEPTH-entry {pc, instr} prefetch queue.
// Define FETCH_PERF_CNT_EN to add saturating perf_fetched_o / perf_squashed_o counters.
module fetch_prefetch_queue #(
  parameter int unsigned           XLEN     = 32,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [XLEN-1:0]       RESET_PC = 'h60
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mem_busy_i,
  output logic            mem_read_o,
  output logic [XLEN-1:0] mem_address_o,
  input  logic            mem_resp_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_squashed_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, req_pc_q;
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [XLEN-1:0]   pc_mem_q    [DEPTH];
  logic [XLEN-1:0]   instr_mem_q [DEPTH];
  logic              push, pop, discard, req_start;
  logic [XLEN-1:0]   target_pc;

  assign target_pc = redirect_pc_i & ~XLEN'(3);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!mem_busy_i && (count_q < DEPTH_C) && !redirect_i) state_d = S_REQ;
      S_REQ: begin
        if (mem_resp_i)      state_d = S_IDLE;
        else if (redirect_i) state_d = S_DROP;
      end
      S_DROP: if (mem_resp_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read_o = (state_q != S_IDLE);
    req_start  = (state_q == S_IDLE) && (state_d == S_REQ);
    push       = (state_q == S_REQ) && mem_resp_i && !redirect_i;
    discard    = mem_resp_i && ((state_q == S_DROP) || ((state_q == S_REQ) && redirect_i));
  end

  assign mem_address_o = req_pc_q;
  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign instr_pc_o    = pc_mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Redirect overrides both the push and the pop of the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (req_start) req_pc_q <= fetch_pc_q;
      if (redirect_i)  fetch_pc_q <= target_pc;
      else if (push)   fetch_pc_q <= req_pc_q + XLEN'(4);
      if (redirect_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, squashed_q, squash_inc;
  logic [32:0] squash_sum;

  always_comb begin
    squash_inc = (redirect_i ? 32'(count_q) : 32'd0) + 32'(discard);
    squash_sum = {1'b0, squashed_q} + {1'b0, squash_inc};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      if (push && (fetched_q != '1)) fetched_q <= fetched_q + 32'd1;
      squashed_q <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end

  assign perf_fetched_o  = fetched_q;
  assign perf_squashed_o = squashed_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: a driver keeps a transaction-level model of
// the expected fetch stream; a separate monitor pops expectations on each decode handshake.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_busy_i = 1'b0;
  logic        mem_read_o;
  logic [31:0] mem_address_o;
  logic        mem_resp_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_squashed_o;
`endif

  fetch_prefetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h60)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_busy_i(mem_busy_i),
    .mem_read_o(mem_read_o), .mem_address_o(mem_address_o),
    .mem_resp_i(mem_resp_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched_o(perf_fetched_o), .perf_squashed_o(perf_squashed_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  bit          outstanding;
  bit          squashed;
  logic [31:0] req_addr;
  logic [31:0] exp_pc;
  int unsigned m_fetched;
  int unsigned m_squashed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    outstanding = 0;
    squashed    = 0;
    req_addr    = 32'h60;
    exp_pc      = 32'h60;
    m_fetched   = 0;
    m_squashed  = 0;
  endtask

  // Reset for one cycle; optionally a stray response arrives while reset is held.
  task automatic do_reset(input bit late_resp);
    @(negedge clk_i);
    rst_i = 1'b1; mem_busy_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b0;
    mem_resp_i = late_resp; mem_rdata_i = 32'hDEAD_BEEF;
    model_reset();
    @(negedge clk_i);
    check("rst_mem_read", {31'b0, mem_read_o}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_mem_address", mem_address_o, 32'h60);
    rst_i = 1'b0; mem_resp_i = 1'b0;
    mem_busy_i = 1'b1;  // hold off the first fetch until the next driven cycle
  endtask

  // One clock of stimulus: observe outputs, drive inputs, advance the model past the next edge.
  task automatic cycle(input bit busy, input bit redir, input logic [31:0] tgt,
                       input bit resp, input bit rdy);
    @(negedge clk_i);
    check("mem_read", {31'b0, mem_read_o}, {31'b0, outstanding});
    if (outstanding) check("mem_address", mem_address_o, req_addr);
    check("instr_valid", {31'b0, instr_valid_o}, {31'b0, exp_q.size() != 0});
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched_o, m_fetched);
    check("perf_squashed", perf_squashed_o, m_squashed);
`endif
    mem_busy_i    = busy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    instr_ready_i = rdy;
    mem_resp_i    = resp && outstanding;
    mem_rdata_i   = $urandom;
    if (mem_resp_i) begin
      if (!redir && !squashed) begin
        exp_q.push_back({req_addr, mem_rdata_i});
        exp_pc = req_addr + 32'd4;
        m_fetched++;
      end else begin
        m_squashed++;
      end
      outstanding = 0;
    end else if (outstanding && redir) begin
      squashed = 1;
    end else if (!outstanding && !busy && exp_q.size() < DEPTH && !redir) begin
      outstanding = 1;
      squashed    = 0;
      req_addr    = exp_pc;
    end
    if (redir) begin
      m_squashed += exp_q.size();
      exp_q.delete();
      exp_pc = tgt & ~32'd3;
    end
  endtask

  // Monitor: each accepted head must be the oldest expected {pc, instr}.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_i && instr_valid_o && instr_ready_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pop: got pc %h with nothing expected", instr_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc_o, e[63:32]);
          check("instr", instr_o, e[31:0]);
        end
      end
    end
  end

  initial begin
    model_reset();

    // Streaming fetch with an always-ready decoder.
    do_reset(0);
    repeat (8) cycle(0, 0, 0, 1, 1);

    // Fill with decode stalled, then drain in order.
    do_reset(0);
    repeat (12) cycle(0, 0, 0, 1, 0);
    check("full_count", exp_q.size(), DEPTH);
    repeat (6) cycle(1, 0, 0, 0, 1);

    // Redirect while a request is pending goes through DROP.
    do_reset(0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 32'h203, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    repeat (4) cycle(0, 0, 0, 1, 1);
    check("drop_target", exp_pc, 32'h208);

    // mem_busy holds off the request.
    do_reset(0);
    repeat (5) cycle(1, 0, 0, 1, 1);
    repeat (4) cycle(0, 0, 0, 1, 1);

    // Redirect coincident with response and pop; then redirect on a full queue with pop.
    do_reset(0);
    repeat (7) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 32'h400, 1, 1);
    repeat (4) cycle(0, 0, 0, 1, 1);
    repeat (10) cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 32'h800, 0, 1);
    repeat (4) cycle(0, 0, 0, 1, 1);

    // Address-space wrap.
    do_reset(0);
    cycle(0, 1, 32'hFFFF_FFFF, 0, 1);
    repeat (6) cycle(0, 0, 0, 1, 1);

    // Reset in the middle of a request with a stray response.
    do_reset(0);
    cycle(0, 0, 0, 0, 1);
    do_reset(1);
    repeat (4) cycle(0, 0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
    end
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
